// File: rtl/soc_mmio_pkg.sv
// Shared address-map constants and region decode for the MMIO fabric.
package soc_mmio_pkg;

    localparam logic [3:0] REG_DMEM_MAX = 4'h7;
    localparam logic [3:0] REG_ACCEL    = 4'h8;
    localparam logic [3:0] REG_LOCAL    = 4'h9;

    localparam logic [2:0] OFF_GPI    = 3'd0;
    localparam logic [2:0] OFF_GPO    = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_MASK   = 3'd3;
    localparam logic [2:0] OFF_CNT    = 3'd4;

    localparam int BUS_ERR_BIT = 31;

    typedef enum logic [1:0] {
        SEL_DMEM,
        SEL_ACCEL,
        SEL_LOCAL,
        SEL_NONE
    } sel_e;

    function automatic sel_e decode_region(input logic [3:0] region);
        if (region <= REG_DMEM_MAX) begin
            return SEL_DMEM;
        end else if (region == REG_ACCEL) begin
            return SEL_ACCEL;
        end else if (region == REG_LOCAL) begin
            return SEL_LOCAL;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/sticky_edge_flag.sv
// Sticky status bit: set by an event (optionally its rising edge),
// cleared by clr; a set in the same cycle as a clear wins.
module sticky_edge_flag #(
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic evt,
    input  logic clr,
    output logic flag
);

    logic r_prev;
    logic r_flag;
    logic w_set;

    assign w_set = evt & ~(EDGE_DET & r_prev);
    assign flag  = r_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_flag <= 1'b0;
        end else begin
            r_prev <= evt;
            if (w_set) begin
                r_flag <= 1'b1;
            end else if (clr) begin
                r_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/soc_mmio_fabric.sv
// MMIO interconnect: routes the core data port to dmem, accelerator
// slots and a local bank (GPI/GPO/status/mask/cycle counter), plus irq.
module soc_mmio_fabric
    import soc_mmio_pkg::*;
#(
    parameter int NUM_ACCEL   = 2,
    parameter int GPI_WIDTH   = 8,
    parameter int GPO_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             addr,
    input  logic [31:0]             write_data,
    input  logic                    WE,
    output logic [31:0]             data_out,
    output logic                    dmem_we,
    input  logic [31:0]             dmem_rd,
    output logic [NUM_ACCEL-1:0]    accel_we,
    input  logic [32*NUM_ACCEL-1:0] accel_rd,
    input  logic [NUM_ACCEL-1:0]    accel_done,
    input  logic [GPI_WIDTH-1:0]    gpi,
    output logic [GPO_WIDTH-1:0]    gpo
    ,
    output logic                    irq
);

    sel_e                 w_sel;
    logic [3:0]           w_slot;
    logic [2:0]           w_off;
    logic                 w_slot_ok;
    logic                 w_wr_local;
    logic                 w_wr_gpo;
    logic                 w_wr_status;
    logic                 w_wr_mask;
    logic                 w_wr_cnt;
    logic                 w_err_evt;
    logic                 w_err_clr;
    logic                 w_err_flag;
    logic [NUM_ACCEL-1:0] w_done_clr;
    logic [NUM_ACCEL-1:0] w_done_flag;
    logic [31:0]          w_status;
    logic [31:0]          w_mask;
    logic [31:0]          w_local_rd;
    logic [31:0]          w_accel_rd;
    logic                 w_unused;

    logic [GPO_WIDTH-1:0] r_gpo;
    logic [NUM_ACCEL-1:0] r_mask_done;
    logic                 r_mask_err;
    logic [31:0]          r_cnt;
    logic                 r_irq;
    logic [GPI_WIDTH-1:0] r_sync [SYNC_STAGES];

    assign w_sel     = decode_region(addr[11:8]);
    assign w_slot    = addr[7:4];
    assign w_off     = addr[4:2];
    assign w_slot_ok = {1'b0, w_slot} < 5'(NUM_ACCEL);
    assign w_unused  = ^{addr[31:12], addr[1:0], write_data};

    assign w_wr_local  = WE & (w_sel == SEL_LOCAL);
    assign w_wr_gpo    = w_wr_local & (w_off == OFF_GPO);
    assign w_wr_status = w_wr_local & (w_off == OFF_STATUS);
    assign w_wr_mask   = w_wr_local & (w_off == OFF_MASK);
    assign w_wr_cnt    = w_wr_local & (w_off == OFF_CNT);

    assign w_done_clr = {NUM_ACCEL{w_wr_status}} & write_data[NUM_ACCEL-1:0];
    assign w_err_clr  = w_wr_status & write_data[BUS_ERR_BIT];
    assign w_err_evt  = WE & ((w_sel == SEL_NONE) |
                              ((w_sel == SEL_ACCEL) & ~w_slot_ok));

    assign dmem_we = WE & (w_sel == SEL_DMEM);

    always_comb begin
        accel_we = '0;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            accel_we[i] = WE & (w_sel == SEL_ACCEL) & (w_slot == 4'(i));
        end
    end

    genvar g;
    for (g = 0; g < NUM_ACCEL; g++) begin : g_done
        sticky_edge_flag #(
            .EDGE_DET (1'b1)
        ) u_done (
            .clk   (clk),
            .reset (reset),
            .evt   (accel_done[g]),
            .clr   (w_done_clr[g]),
            .flag  (w_done_flag[g])
        );
    end

    // Errors are level events: every faulting write re-arms the flag.
    sticky_edge_flag #(
        .EDGE_DET (1'b0)
    ) u_bus_err (
        .clk   (clk),
        .reset (reset),
        .evt   (w_err_evt),
        .clr   (w_err_clr),
        .flag  (w_err_flag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpo       <= '0;
            r_mask_done <= '0;
            r_mask_err  <= 1'b0;
            r_cnt       <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_gpo) begin
                r_gpo <= write_data[GPO_WIDTH-1:0];
            end
            if (w_wr_mask) begin
                r_mask_done <= write_data[NUM_ACCEL-1:0];
                r_mask_err  <= write_data[BUS_ERR_BIT];
            end
            r_cnt <= w_wr_cnt ? 32'd0 : r_cnt + 32'd1;
            r_irq <= (|(w_done_flag & r_mask_done)) | (w_err_flag & r_mask_err);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gpi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_comb begin
        w_status                      = '0;
        w_status[NUM_ACCEL-1:0]       = w_done_flag;
        w_status[BUS_ERR_BIT]         = w_err_flag;
        w_mask                        = '0;
        w_mask[NUM_ACCEL-1:0]         = r_mask_done;
        w_mask[BUS_ERR_BIT]           = r_mask_err;
    end

    always_comb begin
        w_local_rd = '0;
        case (w_off)
            OFF_GPI:    w_local_rd = 32'(r_sync[SYNC_STAGES-1]);
            OFF_GPO:    w_local_rd = 32'(r_gpo);
            OFF_STATUS: w_local_rd = w_status;
            OFF_MASK:   w_local_rd = w_mask;
            OFF_CNT:    w_local_rd = r_cnt;
            default:    w_local_rd = '0;
        endcase
    end

    always_comb begin
        w_accel_rd = '0;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            if (w_slot == 4'(i)) begin
                w_accel_rd = accel_rd[32*i +: 32];
            end
        end
    end

    always_comb begin
        data_out = '0;
        unique case (w_sel)
            SEL_DMEM:  data_out = dmem_rd;
            SEL_ACCEL: data_out = w_slot_ok ? w_accel_rd : 32'd0;
            SEL_LOCAL: data_out = w_local_rd;
            SEL_NONE:  data_out = '0;
            default:   data_out = '0;
        endcase
    end

    assign gpo = r_gpo;
    assign irq = r_irq;

endmodule

// File: tb/tb_soc_mmio_fabric.sv
// Directed bench for soc_mmio_fabric: address map, W1C status,
// irq timing, GPI sync latency, cycle counter and async reset.
module tb_soc_mmio_fabric;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        WE;
    logic [31:0] data_out;
    logic        dmem_we;
    logic [31:0] dmem_rd;
    logic [1:0]  accel_we;
    logic [63:0] accel_rd;
    logic [1:0]  accel_done;
    logic [7:0]  gpi;
    logic [7:0]  gpo;
    logic        irq;

    int n_chk;
    int n_pass;
    int n_fail;

    soc_mmio_fabric #(
        .NUM_ACCEL   (2),
        .GPI_WIDTH   (8),
        .GPO_WIDTH   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .WE         (WE),
        .data_out   (data_out),
        .dmem_we    (dmem_we),
        .dmem_rd    (dmem_rd),
        .accel_we   (accel_we),
        .accel_rd   (accel_rd),
        .accel_done (accel_done),
        .gpi        (gpi),
        .gpo        (gpo),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        write_data = d;
        WE         = 1'b1;
        tick();
        WE         = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        n_fail     = 0;
        reset      = 1'b1;
        addr       = '0;
        write_data = '0;
        WE         = 1'b0;
        dmem_rd    = 32'hDEAD_BEEF;
        accel_rd   = {32'hBBBB_0001, 32'hAAAA_0000};
        accel_done = 2'b00;
        gpi        = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        rd("rst_status", 32'h908, 32'h0);
        rd("rst_mask", 32'h90C, 32'h0);
        rd("rst_cnt", 32'h910, 32'h0);
        chk("rst_gpo", 32'(gpo), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // GPO write and GPI synchroniser latency
        wr(32'h904, 32'h0000_00A5);
        chk("gpo_pin", 32'(gpo), 32'hA5);
        rd("gpo_rd", 32'h904, 32'hA5);
        gpi = 8'h3C;
        rd("gpi_0", 32'h900, 32'h0);
        tick();
        rd("gpi_1", 32'h900, 32'h0);
        tick();
        rd("gpi_2", 32'h900, 32'h3C);

        // done tracking, irq latency, W1C with level held high
        wr(32'h90C, 32'h2);
        rd("mask_rd", 32'h90C, 32'h2);
        accel_done = 2'b10;
        tick();
        rd("done_set", 32'h908, 32'h2);
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_on", 32'(irq), 32'h1);
        wr(32'h908, 32'h2);
        accel_done = 2'b00;
        rd("w1c_high", 32'h908, 32'h0);
        tick();
        chk("irq_off", 32'(irq), 32'h0);
        rd("no_reset", 32'h908, 32'h0);
        accel_done = 2'b10;
        wr(32'h908, 32'h2);
        rd("set_wins", 32'h908, 32'h2);
        accel_done = 2'b00;
        wr(32'h908, 32'h2);
        tick();
        rd("done_clr", 32'h908, 32'h0);
        chk("irq_idle", 32'(irq), 32'h0);

        // unmapped slot and unmapped region errors
        addr       = 32'h820;
        write_data = 32'hFFFF_FFFF;
        WE         = 1'b1;
        #1;
        chk("bad_slot_we", 32'(accel_we), 32'h0);
        tick();
        WE = 1'b0;
        rd("err_status", 32'h908, 32'h8000_0000);
        rd("bad_slot_rd", 32'h820, 32'h0);
        tick();
        chk("err_unmasked", 32'(irq), 32'h0);
        wr(32'h908, 32'h8000_0000);
        rd("err_clr", 32'h908, 32'h0);
        wr(32'h90C, 32'hFFFF_FFFF);
        rd("mask_bits", 32'h90C, 32'h8000_0003);
        wr(32'hA00, 32'h1);
        rd("region_err", 32'h908, 32'h8000_0000);
        rd("region_rd", 32'hA00, 32'h0);
        tick();
        chk("err_irq", 32'(irq), 32'h1);
        wr(32'h908, 32'h8000_0000);
        tick();
        chk("err_irq_off", 32'(irq), 32'h0);
        wr(32'h918, 32'hFFFF_FFFF);
        rd("rsvd_noerr", 32'h908, 32'h0);
        rd("rsvd_rd", 32'h914, 32'h0);

        // cycle counter clear, count and wrap
        wr(32'h910, 32'h0);
        rd("cnt_clr", 32'h910, 32'h0);
        repeat (10) tick();
        rd("cnt_10", 32'h910, 32'd10);
        force dut.r_cnt = 32'hFFFF_FFFF;
        rd("cnt_max", 32'h910, 32'hFFFF_FFFF);
        release dut.r_cnt;
        tick();
        rd("cnt_wrap", 32'h910, 32'h0);

        // dmem and accelerator routing
        addr       = 32'h010;
        write_data = 32'h1234;
        WE         = 1'b1;
        #1;
        chk("dmem_we_wr", 32'(dmem_we), 32'h1);
        chk("dmem_no_acc", 32'(accel_we), 32'h0);
        tick();
        WE = 1'b0;
        #1;
        chk("dmem_we_rd", 32'(dmem_we), 32'h0);
        chk("dmem_rd", data_out, 32'hDEAD_BEEF);
        addr = 32'h810;
        WE   = 1'b1;
        #1;
        chk("acc1_we", 32'(accel_we), 32'h2);
        chk("acc1_rd", data_out, 32'hBBBB_0001);
        chk("acc_no_dmem", 32'(dmem_we), 32'h0);
        WE   = 1'b0;
        addr = 32'h800;
        #1;
        chk("acc0_rd", data_out, 32'hAAAA_0000);
        chk("acc_we_idle", 32'(accel_we), 32'h0);

        // asynchronous reset mid-stream
        wr(32'h90C, 32'h2);
        accel_done = 2'b10;
        tick();
        tick();
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_gpo", 32'(gpo), 32'hA5);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_gpo", 32'(gpo), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        rd("mid_rst_stat", 32'h908, 32'h0);
        rd("mid_rst_mask", 32'h90C, 32'h0);
        rd("mid_rst_cnt", 32'h910, 32'h0);
        rd("mid_rst_gpi", 32'h900, 32'h0);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/soc_mmio_fabric.md
Name: soc_mmio_fabric

Overview:
- Parametrised memory-mapped interconnect between the single-cycle MIPS data port and the SoC peripherals. It replaces the fixed-function SoC glue.
- Decodes the data address to the external data memory, to NUM_ACCEL accelerator slots, and to a local register bank.
- The local register bank holds synchronised GPI, GPO, sticky accelerator-done status with write-1-to-clear, an interrupt mask and a free-running cycle counter.
- Produces one combined interrupt output.

Parameters:
- NUM_ACCEL, 2, number of accelerator slots (1..16).
- GPI_WIDTH, 8, general-purpose input width (1..32).
- GPO_WIDTH, 8, general-purpose output width (1..32).
- SYNC_STAGES, 2, GPI synchroniser depth (>=2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from core; addr[1:0] ignored.
- write_data  in  32  store data from core.
- WE  in  1  store strobe, sampled at posedge.
- data_out  out  32  load data to core; combinational.
- dmem_we  out  1  write enable to data memory.
- dmem_rd  in  32  data memory read data.
- accel_we  out  NUM_ACCEL  one-hot write enable per slot.
- accel_rd  in  32*NUM_ACCEL  slot read data, slot k at [32k+31:32k].
- accel_done  in  NUM_ACCEL  level done signal per slot.
- gpi  in  GPI_WIDTH  asynchronous external inputs.
- gpo  out  GPO_WIDTH  registered outputs.
- irq  out  1  |(done_status & irq_mask), registered.

Behaviour:
Address map (addr[11:8]; addr[31:12] ignored):
- 0x0-0x7 selects dmem. dmem_we = WE. data_out = dmem_rd.
- 0x8 selects accelerator slot k = addr[7:4].
  - If k < NUM_ACCEL: accel_we[k] = WE and data_out = slot k read data.
  - If k >= NUM_ACCEL: write dropped, read 0, bus_err set.
- 0x9 selects the local register bank, decoded on addr[4:2]:
  - 0 GPI (RO): zero-extended synchronised gpi.
  - 1 GPO (RW): low GPO_WIDTH bits.
  - 2 DONE_STATUS: bits [NUM_ACCEL-1:0] sticky done, bit 31 bus_err. Writing a 1 clears that bit.
  - 3 IRQ_MASK (RW): bits [NUM_ACCEL-1:0] mask done bits, bit 31 masks bus_err.
  - 4 CYCLE_CNT: RO; any write clears it.
  - 5-7: read 0, write dropped, no error.
- Any other region: read 0, write dropped, bus_err set if WE is high.
- All enables are zero whenever WE=0. A read never changes state.

Reads:
- data_out is purely combinational from addr and the current register values. This gives zero read latency, as the single-cycle core requires.

Writes:
- Take effect at the posedge where WE=1. Read-back is visible in the following cycle.

Done tracking:
- accel_done is registered once into done_q.
- Rise is detected when accel_done=1 and done_q=0; it sets done_status[k] at the next posedge. A level held high never re-sets the bit after it is cleared.
- If a set and a write-1-to-clear land in the same cycle, the set wins and the bit stays 1.
- bus_err follows the same rule: an error and a W1C in the same cycle leave bus_err=1.

GPI:
- SYNC_STAGES flop chain, no reset dependency on gpi.
- A gpi change is visible on a GPI read after exactly SYNC_STAGES posedges.

CYCLE_CNT:
- Increments every cycle and wraps from 0xFFFFFFFF to 0.
- A write clears it. Clear wins over increment, so the value reads 0 in the cycle after the write.

irq:
- Registered, so it asserts 1 cycle after the enabling status or mask change.

Reset (asynchronous):
- gpo, done_status, bus_err, irq_mask, done_q, CYCLE_CNT, the sync chain and irq all go to 0.
- dmem_we and accel_we are combinational and are 0 while WE=0.
- Reset asserted mid-operation discards all pending state with no partial update.

Decomposition:
- Package soc_mmio_pkg holds:
  - region codes: REG_DMEM_MAX 0x7, REG_ACCEL 0x8, REG_LOCAL 0x9;
  - local offsets: OFF_GPI 0, OFF_GPO 1, OFF_STATUS 2, OFF_MASK 3, OFF_CNT 4;
  - BUS_ERR_BIT 31.
- One sub-module, sticky_edge_flag:
  - inputs evt, clr; output flag; internal previous-level register;
  - optional edge-detect parameter; set priority over clear.
  - Instantiated NUM_ACCEL times with edge detect on, plus once for bus_err with edge detect off.

Test Plan:
1. Reset, then read 0x908, 0x90C and 0x910 with WE=0 -> each returns 0; gpo=0; irq=0.
2. Write 0x0000_00A5 to 0x904 -> gpo=0xA5 at the next posedge and a read of 0x904 returns 0xA5. Set gpi=0x3C -> a read of 0x900 returns 0 for one cycle, then 0x3C after 2 posedges.
3. Pulse accel_done[1] high for 3 cycles with IRQ_MASK=0x2 -> DONE_STATUS=0x2 and irq=1 one cycle later. Write 0x2 to 0x908 while done is still high -> DONE_STATUS=0, no re-set. A new rise on accel_done[1] in the same cycle as a W1C -> DONE_STATUS stays 0x2.
4. With NUM_ACCEL=2, write to 0x820 -> accel_we=0, bus_err=1, a read of 0x908 returns 0x8000_0000, a read of 0x820 returns 0. Write 0x8000_0000 to 0x908 -> bus_err=0.
5. Run 10 cycles -> CYCLE_CNT reads 10. Write to 0x910 -> reads 0 in the next cycle. Force the counter to 0xFFFFFFFF (bench hierarchical deposit) -> wraps to 0.
6. Write 0x1234 to 0x010, then read 0x010 -> dmem_we=1 during the write and data_out equals dmem_rd. Write to 0x810 -> accel_we=2'b10. Assert reset mid-stream -> every register reads 0 immediately.
